// File: rtl/pipelined_cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// default geometry, stage-count helper and the operation encoding that
// callers use to drive in_sub.
package pipelined_cla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG_W = 8;

    // Operation select; OP_SUB maps directly onto in_sub = 1.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Number of pipeline stages, one per SEG_W-bit segment.
    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_segment.sv
// cla_segment: combinational SEG_W-bit carry-lookahead adder made of 4-bit
// lookahead groups. Group generate/propagate terms feed a group carry chain;
// inside each group the bit carries are expanded in full lookahead form.
// c_msb is the carry into the top bit, used for signed overflow.
module cla_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    localparam int NGRP = SEG_W / 4;

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] c;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    grp_c;
    logic             carry_v;

    assign g = a & b;
    assign p = a ^ b;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : gen_grp
            localparam int B = gi * 4;

            assign grp_g[gi] = g[B+3]
                             | (p[B+3] & g[B+2])
                             | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p[gi] = &p[B+3:B];

            assign c[B]   = grp_c[gi];
            assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
        end
    endgenerate

    // Carry chain across the 4-bit groups, driven by group G/P only.
    always_comb begin
        grp_c   = '0;
        carry_v = cin;
        for (int k = 0; k < NGRP; k++) begin
            grp_c[k] = carry_v;
            carry_v  = grp_g[k] | (grp_p[k] & carry_v);
        end
        grp_c[NGRP] = carry_v;
    end

    assign sum   = p ^ c;
    assign cout  = grp_c[NGRP];
    assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit adder/subtractor resolving SEG_W bits per
// stage with an elastic valid/ready pipeline (one beat per cycle, latency
// NSEG). Each stage keeps the low sum bits resolved so far, the not yet
// consumed upper operand bits and its segment carry-out.
// Optional macro PIPELINED_CLA_FLAGS_EN adds registered out_zero/out_neg.
module pipelined_cla_adder
    import pipelined_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
`ifdef PIPELINED_CLA_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_neg
`endif
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    genvar gi;
    generate
        if ((SEG_W % 4 != 0) || (WIDTH % SEG_W != 0) || (WIDTH < SEG_W)) begin : g_param_check
            $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_W and SEG_W a multiple of 4");
        end
    endgenerate

    logic [NSEG-1:0]  stage_valid;
    logic [NSEG-1:0]  stage_ready;
    logic             ready_v;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is A + ~B + 1; the caller's carry-in is ignored then.
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;

    // Ready ripples back from the consumer: a stage may load when it is empty
    // or when the stage after it is itself able to move.
    always_comb begin
        stage_ready = '0;
        ready_v     = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            ready_v        = ~stage_valid[k] | ready_v;
            stage_ready[k] = ready_v;
        end
    end

    generate
        for (gi = 0; gi < NSEG; gi++) begin : gen_stage
            localparam int LO  = gi * SEG_W;
            localparam int HI  = LO + SEG_W;
            localparam int REM = WIDTH - HI;

            logic [SEG_W-1:0] seg_a;
            logic [SEG_W-1:0] seg_b;
            logic [SEG_W-1:0] seg_sum;
            logic             seg_cin;
            logic             seg_cout;
            logic             seg_cmsb;
            logic             up_valid;
            logic [HI-1:0]    sum_next;
            logic [HI-1:0]    sum_reg;
            logic             valid_reg;
            logic             carry_reg;

            if (gi == 0) begin : g_src
                assign seg_a    = in_a[SEG_W-1:0];
                assign seg_b    = b_eff[SEG_W-1:0];
                assign seg_cin  = cin_eff;
                assign up_valid = in_valid;
                assign sum_next = seg_sum;
            end else begin : g_src
                assign seg_a    = gen_stage[gi-1].g_ops.a_reg[SEG_W-1:0];
                assign seg_b    = gen_stage[gi-1].g_ops.b_reg[SEG_W-1:0];
                assign seg_cin  = gen_stage[gi-1].carry_reg;
                assign up_valid = stage_valid[gi-1];
                assign sum_next = {seg_sum, gen_stage[gi-1].sum_reg};
            end

            cla_segment #(
                .SEG_W (SEG_W)
            ) u_seg (
                .a     (seg_a),
                .b     (seg_b),
                .cin   (seg_cin),
                .sum   (seg_sum),
                .cout  (seg_cout),
                .c_msb (seg_cmsb)
            );

            // Stage valid follows upstream whenever the stage may load; data
            // only moves with a real beat so idle cycles leave it untouched.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    carry_reg <= 1'b0;
                    sum_reg   <= '0;
                end else if (stage_ready[gi]) begin
                    valid_reg <= up_valid;
                    if (up_valid) begin
                        carry_reg <= seg_cout;
                        sum_reg   <= sum_next;
                    end
                end
            end

            assign stage_valid[gi] = valid_reg;

            if (REM > 0) begin : g_ops
                logic [REM-1:0] a_reg;
                logic [REM-1:0] b_reg;
                logic [REM-1:0] a_next;
                logic [REM-1:0] b_next;
                logic           unused_cmsb;

                // Only the last stage needs the carry into the MSB.
                assign unused_cmsb = seg_cmsb;

                if (gi == 0) begin : g_in
                    assign a_next = in_a[WIDTH-1:HI];
                    assign b_next = b_eff[WIDTH-1:HI];
                end else begin : g_in
                    assign a_next = gen_stage[gi-1].g_ops.a_reg[REM+SEG_W-1:SEG_W];
                    assign b_next = gen_stage[gi-1].g_ops.b_reg[REM+SEG_W-1:SEG_W];
                end

                // Carry the unresolved upper operand bits to the next stage.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_reg <= '0;
                        b_reg <= '0;
                    end else if (stage_ready[gi] && up_valid) begin
                        a_reg <= a_next;
                        b_reg <= b_next;
                    end
                end
            end else begin : g_last
                logic cmsb_reg;

                // Carry into the MSB, kept beside carry-out for overflow.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        cmsb_reg <= 1'b0;
                    end else if (stage_ready[gi] && up_valid) begin
                        cmsb_reg <= seg_cmsb;
                    end
                end
            end

`ifdef PIPELINED_CLA_FLAGS_EN
            logic zero_next;
            logic zero_reg;

            if (gi == 0) begin : g_zsrc
                assign zero_next = ~|seg_sum;
            end else begin : g_zsrc
                assign zero_next = gen_stage[gi-1].zero_reg & (~|seg_sum);
            end

            // Running "all resolved bits are zero" flag, one segment per stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    zero_reg <= 1'b0;
                end else if (stage_ready[gi] && up_valid) begin
                    zero_reg <= zero_next;
                end
            end
`endif
        end
    endgenerate

    assign in_ready  = stage_ready[0];
    assign out_valid = stage_valid[NSEG-1];
    assign out_sum   = gen_stage[NSEG-1].sum_reg;
    assign out_cout  = gen_stage[NSEG-1].carry_reg;
    assign out_ovf   = gen_stage[NSEG-1].g_last.cmsb_reg ^ gen_stage[NSEG-1].carry_reg;

`ifdef PIPELINED_CLA_FLAGS_EN
    assign out_zero = gen_stage[NSEG-1].zero_reg;
    assign out_neg  = gen_stage[NSEG-1].sum_reg[WIDTH-1];
`endif

endmodule
